// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that gates a
// multi-slot issue bundle on RAW, WAW and same-bundle conflicts, and holds
// the front end in a fixed-length flush window after a taken branch.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 128,
    parameter int ADDR_W    = 7,
    parameter int NUM_PIPES = 2,
    parameter int NUM_SRC   = 3,
    parameter int LAT_W     = 4,
    parameter int MAX_LAT   = 7,
    parameter int FLUSH_LEN = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PIPES-1:0]                issue_valid,
    input  logic [NUM_PIPES-1:0]                issue_wr,
    input  logic [NUM_PIPES*ADDR_W-1:0]         issue_dst,
    input  logic [NUM_PIPES*LAT_W-1:0]          issue_lat,
    input  logic [NUM_PIPES*NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_PIPES*NUM_SRC-1:0]        src_used,
    input  logic                                is_branch,
    input  logic                                branch_taken,
    output logic                                stall,
    output logic                                dependent_stall,
    output logic                                flush,
    output logic [NUM_PIPES-1:0]                issue_accept,
    output logic [ADDR_W:0]                     busy_count
);

    localparam int                FCNT_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [LAT_W-1:0]  LAT_CLAMP   = LAT_W'(MAX_LAT);
    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_LEN - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        FLUSHING = 1'b1
    } flush_state_e;

    // Scoreboard: cycles remaining until each register is forwardable.
    logic [LAT_W-1:0]     cnt_q [NUM_REGS];
    logic [LAT_W-1:0]     cnt_d [NUM_REGS];
    logic [ADDR_W:0]      busy_count_q;
    logic [ADDR_W:0]      busy_count_d;

    flush_state_e         state_q;
    flush_state_e         state_d;
    logic [FCNT_W-1:0]    fcnt_q;
    logic [FCNT_W-1:0]    fcnt_d;
    logic                 flush_q;
    logic                 flush_d;

    // Per-slot decoded fields.
    logic [ADDR_W-1:0]    dst     [NUM_PIPES];
    logic [LAT_W-1:0]     lat_eff [NUM_PIPES];
    logic [ADDR_W-1:0]    src     [NUM_PIPES][NUM_SRC];

    logic                 raw_hit;
    logic                 waw_hit;
    logic                 bundle_conflict;
    logic                 stall_c;
    logic                 dep_stall_c;
    logic [NUM_PIPES-1:0] accept_c;

    // Requests beyond the pipeline's deepest latency are treated as the deepest.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        return (lat > LAT_CLAMP) ? LAT_CLAMP : lat;
    endfunction

    // Addresses outside the tracked range always read as ready.
    function automatic logic [LAT_W-1:0] cnt_at(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) ? cnt_q[a] : '0;
    endfunction

    // Slice the flat port vectors into per-slot fields.
    always_comb begin
        for (int p = 0; p < NUM_PIPES; p++) begin
            dst[p]     = issue_dst[p*ADDR_W +: ADDR_W];
            lat_eff[p] = clamp_lat(issue_lat[p*LAT_W +: LAT_W]);
            for (int s = 0; s < NUM_SRC; s++) begin
                src[p][s] = src_addr[(p*NUM_SRC+s)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Hazard detection and issue gating; flush overrides every other reason.
    always_comb begin
        raw_hit         = 1'b0;
        waw_hit         = 1'b0;
        bundle_conflict = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            if (issue_valid[p]) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (src_used[p*NUM_SRC+s] && (cnt_at(src[p][s]) != '0)) begin
                        raw_hit = 1'b1;
                    end
                end
                // A shorter write must not overtake an outstanding longer one.
                if (issue_wr[p] && (lat_eff[p] != '0) && (cnt_at(dst[p]) >= lat_eff[p])) begin
                    waw_hit = 1'b1;
                end
            end
        end
        for (int p = 1; p < NUM_PIPES; p++) begin
            for (int q = 0; q < p; q++) begin
                if (issue_valid[p] && issue_valid[q] && issue_wr[q]) begin
                    for (int s = 0; s < NUM_SRC; s++) begin
                        if (src_used[p*NUM_SRC+s] && (src[p][s] == dst[q])) begin
                            bundle_conflict = 1'b1;
                        end
                    end
                    if (issue_wr[p] && (dst[p] == dst[q])) begin
                        bundle_conflict = 1'b1;
                    end
                end
            end
        end
        stall_c     = !flush_q && (raw_hit || waw_hit);
        dep_stall_c = !flush_q && !stall_c && bundle_conflict;
        for (int p = 0; p < NUM_PIPES; p++) begin
            accept_c[p] = issue_valid[p] && !flush_q && !stall_c && ((p == 0) || !dep_stall_c);
        end
    end

    // Next counter values: a new accepted write loads, otherwise count down.
    always_comb begin
        busy_count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_W'(1)) : '0;
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (accept_c[p] && issue_wr[p] && (lat_eff[p] != '0) &&
                    (dst[p] == ADDR_W'(r))) begin
                    cnt_d[r] = lat_eff[p] - LAT_W'(1);
                end
            end
            busy_count_d = busy_count_d + (ADDR_W+1)'(cnt_d[r] != '0);
        end
    end

    // Flush window next state; a taken branch always restarts the window.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (is_branch && branch_taken) begin
                    state_d = FLUSHING;
                    fcnt_d  = FCNT_RELOAD;
                end
            end
            FLUSHING: begin
                if (is_branch && branch_taken) begin
                    fcnt_d = FCNT_RELOAD;
                end else if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
        flush_d = (state_d == FLUSHING);
    end

    // Scoreboard counters and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_count_q <= busy_count_d;
        end
    end

    // Flush FSM state, window counter and registered flush output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flush_q <= flush_d;
        end
    end

    assign stall           = stall_c;
    assign dependent_stall = dep_stall_c;
    assign issue_accept    = accept_c;
    assign flush           = flush_q;
    assign busy_count      = busy_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios followed by random bundles, all
// compared against a cycle-stamped reference model of the scoreboard.
module tb_hazard_scoreboard;

    localparam int NR   = 128;
    localparam int AW   = 7;
    localparam int NP   = 2;
    localparam int NS   = 3;
    localparam int LW   = 4;
    localparam int MAXL = 7;
    localparam int FL   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     issue_valid;
    logic [NP-1:0]     issue_wr;
    logic [NP*AW-1:0]  issue_dst;
    logic [NP*LW-1:0]  issue_lat;
    logic [NP*NS*AW-1:0] src_addr;
    logic [NP*NS-1:0]  src_used;
    logic              is_branch;
    logic              branch_taken;
    logic              stall;
    logic              dependent_stall;
    logic              flush;
    logic [NP-1:0]     issue_accept;
    logic [AW:0]       busy_count;

    hazard_scoreboard #(
        .NUM_REGS(NR), .ADDR_W(AW), .NUM_PIPES(NP), .NUM_SRC(NS),
        .LAT_W(LW), .MAX_LAT(MAXL), .FLUSH_LEN(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_dst(issue_dst), .issue_lat(issue_lat),
        .src_addr(src_addr), .src_used(src_used),
        .is_branch(is_branch), .branch_taken(branch_taken),
        .stall(stall), .dependent_stall(dependent_stall), .flush(flush),
        .issue_accept(issue_accept), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    // Reference model: absolute cycle at which each register becomes
    // forwardable, and the last cycle of the current flush window.
    int ready_at [NR];
    int flush_end;
    int now;
    int tests;
    int fails;

    logic          exp_stall;
    logic          exp_dstall;
    logic          exp_flush;
    logic [NP-1:0] exp_acc;
    int            exp_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, req, now);
        end
    endtask

    function automatic int remaining(input int r);
        return (ready_at[r] > now) ? (ready_at[r] - now) : 0;
    endfunction

    function automatic int eff_lat(input int p);
        int l;
        l = int'(issue_lat[p*LW +: LW]);
        return (l > MAXL) ? MAXL : l;
    endfunction

    function automatic int dst_of(input int p);
        return int'(issue_dst[p*AW +: AW]);
    endfunction

    function automatic int src_of(input int p, input int s);
        return int'(src_addr[(p*NS+s)*AW +: AW]);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        flush_end = -1;
        now = 0;
    endtask

    task automatic compute();
        logic raw, waw, dep;
        raw = 1'b0; waw = 1'b0; dep = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (issue_valid[p]) begin
                for (int s = 0; s < NS; s++)
                    if (src_used[p*NS+s] && remaining(src_of(p, s)) != 0) raw = 1'b1;
                if (issue_wr[p] && eff_lat(p) >= 1 && remaining(dst_of(p)) >= eff_lat(p)) waw = 1'b1;
            end
        end
        for (int p = 1; p < NP; p++) begin
            for (int q = 0; q < p; q++) begin
                if (issue_valid[p] && issue_valid[q] && issue_wr[q]) begin
                    for (int s = 0; s < NS; s++)
                        if (src_used[p*NS+s] && src_of(p, s) == dst_of(q)) dep = 1'b1;
                    if (issue_wr[p] && dst_of(p) == dst_of(q)) dep = 1'b1;
                end
            end
        end
        exp_flush  = (now <= flush_end);
        exp_stall  = !exp_flush && (raw || waw);
        exp_dstall = !exp_flush && !exp_stall && dep;
        for (int p = 0; p < NP; p++)
            exp_acc[p] = issue_valid[p] && !exp_flush && !exp_stall && (p == 0 || !exp_dstall);
        exp_busy = 0;
        for (int r = 0; r < NR; r++) if (remaining(r) != 0) exp_busy++;
    endtask

    // Compare every output against the model mid-cycle.
    task automatic sample();
        @(negedge clk);
        compute();
        chk("stall", stall, exp_stall);
        chk("dependent_stall", dependent_stall, exp_dstall);
        chk("flush", flush, exp_flush);
        chk("issue_accept", issue_accept, exp_acc);
        chk("busy_count", busy_count, exp_busy);
    endtask

    // Clock edge: apply the model's own acceptance decisions.
    task automatic advance();
        @(posedge clk);
        for (int p = 0; p < NP; p++)
            if (exp_acc[p] && issue_wr[p] && eff_lat(p) >= 1)
                ready_at[dst_of(p)] = now + eff_lat(p);
        if (is_branch && branch_taken) flush_end = now + FL;
        now++;
        #1;
    endtask

    task automatic clr();
        issue_valid = '0; issue_wr = '0; issue_dst = '0; issue_lat = '0;
        src_addr = '0; src_used = '0; is_branch = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic slot(input int p, input bit v, input bit w, input int d, input int l);
        issue_valid[p] = v;
        issue_wr[p] = w;
        issue_dst[p*AW +: AW] = AW'(d);
        issue_lat[p*LW +: LW] = LW'(l);
    endtask

    task automatic use_src(input int p, input int s, input int a);
        src_used[p*NS+s] = 1'b1;
        src_addr[(p*NS+s)*AW +: AW] = AW'(a);
    endtask

    task automatic drain();
        clr();
        repeat (8) begin sample(); advance(); end
    endtask

    task automatic randomize_inputs();
        for (int p = 0; p < NP; p++) begin
            slot(p, ($urandom % 4) != 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            for (int s = 0; s < NS; s++) begin
                src_used[p*NS+s] = ($urandom % 3) == 0;
                src_addr[(p*NS+s)*AW +: AW] = AW'($urandom_range(0, 7));
            end
        end
        is_branch    = ($urandom % 10) == 0;
        branch_taken = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();

        // Reset with random inputs, then release between edges.
        rst_n = 1'b0;
        randomize_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clr();
        sample();
        chk("reset_flush", flush, 0);
        chk("reset_busy", busy_count, 0);
        chk("reset_stall_idle", stall, 0);
        advance();
        slot(0, 1, 1, 1, 1);
        slot(1, 1, 1, 2, 1);
        sample();
        chk("reset_indep_accept", issue_accept, 2'b11);
        advance();
        drain();

        // RAW countdown on r5 with latency 4.
        clr();
        slot(0, 1, 1, 5, 4);
        sample();
        chk("raw_producer_accept", issue_accept, 2'b01);
        advance();
        clr();
        slot(0, 1, 0, 0, 0);
        use_src(0, 0, 5);
        for (int t = 1; t <= 3; t++) begin
            sample();
            chk("raw_consumer_stall", stall, 1);
            chk("raw_busy_one", busy_count, 1);
            advance();
        end
        sample();
        chk("raw_consumer_accept", issue_accept, 2'b01);
        advance();
        drain();

        // Same-bundle dependency on r9.
        clr();
        slot(0, 1, 1, 9, 3);
        slot(1, 1, 0, 0, 0);
        use_src(1, 1, 9);
        sample();
        chk("bundle_dep_stall", dependent_stall, 1);
        chk("bundle_accept_older", issue_accept, 2'b01);
        advance();
        clr();
        slot(0, 1, 0, 0, 0);
        use_src(0, 1, 9);
        for (int t = 1; t <= 2; t++) begin
            sample();
            chk("bundle_follow_stall", stall, 1);
            advance();
        end
        sample();
        chk("bundle_follow_accept", issue_accept, 2'b01);
        advance();
        drain();

        // WAW ordering on r3: long write then short write.
        clr();
        slot(0, 1, 1, 3, 6);
        sample();
        advance();
        clr();
        slot(0, 1, 1, 3, 2);
        for (int t = 1; t <= 4; t++) begin
            sample();
            chk("waw_stall", stall, 1);
            advance();
        end
        sample();
        chk("waw_accept", issue_accept, 2'b01);
        advance();
        drain();

        // Flush window, extended by a second taken branch.
        clr();
        slot(0, 1, 0, 0, 0);
        is_branch = 1'b1;
        branch_taken = 1'b1;
        sample();
        chk("flush_branch_cycle_accept", issue_accept, 2'b01);
        advance();
        is_branch = 1'b0;
        branch_taken = 1'b0;
        sample();
        chk("flush_t1", flush, 1);
        chk("flush_t1_no_issue", issue_accept, 0);
        advance();
        is_branch = 1'b1;
        branch_taken = 1'b1;
        sample();
        chk("flush_t2", flush, 1);
        advance();
        is_branch = 1'b0;
        branch_taken = 1'b0;
        for (int t = 3; t <= 4; t++) begin
            sample();
            chk("flush_extended", flush, 1);
            chk("flush_ext_no_issue", issue_accept, 0);
            advance();
        end
        sample();
        chk("flush_done", flush, 0);
        chk("flush_done_accept", issue_accept, 2'b01);
        advance();
        drain();

        // Latency clamp (15 -> 7) and untracked write (latency 0).
        clr();
        slot(0, 1, 1, 20, 15);
        sample();
        advance();
        clr();
        slot(0, 1, 0, 0, 0);
        use_src(0, 2, 20);
        for (int t = 1; t <= 6; t++) begin
            sample();
            chk("clamp_stall", stall, 1);
            advance();
        end
        sample();
        chk("clamp_accept", issue_accept, 2'b01);
        advance();
        clr();
        slot(0, 1, 1, 21, 0);
        sample();
        advance();
        clr();
        slot(0, 1, 0, 0, 0);
        use_src(0, 0, 21);
        sample();
        chk("untracked_accept", issue_accept, 2'b01);
        chk("untracked_busy", busy_count, 0);
        advance();

        // Reset in the middle of a pending write and flush window.
        clr();
        slot(0, 1, 1, 30, 7);
        is_branch = 1'b1;
        branch_taken = 1'b1;
        sample();
        advance();
        clr();
        sample();
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy_count, 0);
        chk("midreset_flush", flush, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        slot(0, 1, 0, 0, 0);
        use_src(0, 0, 30);
        sample();
        chk("midreset_no_stale_stall", issue_accept, 2'b01);
        advance();

        // Random bundles over a small register window to force hazards.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the dual-issue hazard unit. It replaces per-stage destination comparison with a per-register countdown scoreboard. The block sits between decode and register fetch. It tracks in-flight writes from NUM_PIPES issue slots and gates issue on RAW, WAW and same-bundle conflicts. It also generates a multi-cycle flush after a taken branch.

## Interface
Parameters:
- NUM_REGS, 128: architectural registers tracked.
- ADDR_W, 7: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- NUM_PIPES, 2: issue slots. Slot 0 is even and older; slot 1 is odd and younger.
- NUM_SRC, 3: source operands per slot (ra, rb, rc).
- LAT_W, 4: latency field width.
- MAX_LAT, 7: latency clamp; larger requests are clamped to this value.
- FLUSH_LEN, 2: cycles flush is held after a taken branch; must be >= 1.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: reset, **asynchronous, active-low**.
- issue_valid, in, NUM_PIPES: slot p holds a real instruction (not nop/lnop/stop).
- issue_wr, in, NUM_PIPES: slot p writes a register.
- issue_dst, in, NUM_PIPES*ADDR_W: destination per slot.
- issue_lat, in, NUM_PIPES*LAT_W: result latency per slot, in cycles until forwardable.
- src_addr, in, NUM_PIPES*NUM_SRC*ADDR_W: source addresses.
- src_used, in, NUM_PIPES*NUM_SRC: the source is actually read (e.g. rc only for selb, fma, br*z).
- is_branch, in, 1: a branch is resolving this cycle.
- branch_taken, in, 1: resolution outcome.
- stall, out, 1: no slot issues this cycle.
- dependent_stall, out, 1: slot 0 issues and slots >= 1 hold.
- flush, out, 1: squash the front end; no issue.
- issue_accept, out, NUM_PIPES: slot p is accepted this cycle.
- busy_count, out, ADDR_W+1: number of registers with a nonzero counter.

## Operation
- Scoreboard state:
  - cnt[r], LAT_W bits, one per register. cnt[r] is the number of cycles until r is forwardable.
  - A register is ready when cnt[r] == 0.
- Effective latency: L = min(issue_lat, MAX_LAT). L == 0 means the write is untracked and no counter is loaded.
- RAW hazard: any used source of any valid slot has cnt[src] != 0.
- WAW hazard: a valid writing slot with L >= 1 has cnt[dst] >= L. This preserves writeback order.
- stall = valid-slot RAW | WAW, with flush taking priority.
- dependent_stall is asserted when not stall, not flush, and some slot p >= 1 conflicts with an older slot q < p in the same bundle. A conflict is either:
  - slot p uses a source equal to slot q's dst while slot q writes, or
  - both slots write the same dst.
- Accept rules:
  - issue_accept[0] = issue_valid[0] & !stall & !flush.
  - issue_accept[p>=1] = issue_valid[p] & !stall & !flush & !dependent_stall.
- Counter update, every edge, per register:
  - If an accepted writing slot has dst == r and L >= 1, then cnt[r] <= L-1. Load wins over decrement.
  - Otherwise, if cnt[r] != 0, then cnt[r] <= cnt[r]-1.
  - Two accepted slots never load the same r, because dependent_stall prevents it.
- Flush FSM: states IDLE and FLUSHING, with down-counter fcnt.
  - IDLE to FLUSHING when is_branch & branch_taken; fcnt <= FLUSH_LEN-1.
  - FLUSHING: fcnt decrements. Return to IDLE when fcnt == 0 and no new taken branch.
  - A new taken branch while FLUSHING reloads fcnt to FLUSH_LEN-1.
  - flush = (state == FLUSHING).
  - Counters keep decrementing during flush, because older in-flight writes remain valid.
- busy_count is registered. It equals the popcount of the next-state nonzero counters.

## Timing
- Reset (rst_n low, async): all cnt = 0, state IDLE, fcnt = 0, flush = 0, busy_count = 0. stall, dependent_stall and issue_accept evaluate to 0 when there is no valid input.
- stall, dependent_stall and issue_accept are combinational from the registered cnt and the current inputs.
- flush is registered. It is first high the cycle after the taken branch and stays high for exactly FLUSH_LEN cycles.
- A producer accepted in cycle t with latency L lets a dependent issue no earlier than cycle t+L. With L = 1, back-to-back issue in the next bundle is allowed.
- Reset mid-operation clears all pending state immediately; no stale stall survives.

## Test plan
- Reset: hold rst_n low with random inputs, release. Then flush=0, busy_count=0, and an independent valid bundle gives issue_accept=2'b11.
- RAW countdown: slot0 writes r5 with L=4 at t=0. A consumer of r5 is stalled at t=1..3 and accepted at t=4; busy_count=1 for t=1..3.
- Same-bundle dependency: slot0 writes r9, slot1 reads r9. Then dependent_stall=1 and issue_accept=2'b01. The next cycle, slot1 stalls until the r9 counter reaches 0.
- WAW ordering: r3 loaded with L=6. One cycle later, a write to r3 with L=2 gives stall=1 until cnt[r3] < 2, then accepts.
- Flush: taken branch at t=0 with FLUSH_LEN=2 gives flush high at t=1..2 with issue_accept=0. A second taken branch at t=2 extends flush through t=4.
- Clamp and untracked writes: L=15 loads MAX_LAT-1=6. L=0 leaves cnt unchanged, and consumers issue the next cycle.
